// File: rtl/video_frame_capture_if.sv
// rtl/video_frame_capture_if.sv - video input stream and frame-buffer write port bundle
interface video_frame_capture_if #(
    parameter int ADDR_W = 16
);
    logic              i_vs;
    logic              i_hs;
    logic              i_de;
    logic [7:0]        i_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;

    // capture block side: consumes video, drives the frame-buffer write port
    modport slave (
        input  i_vs, i_hs, i_de, i_data,
        output o_wr_en, o_wr_addr, o_wr_data
    );

    // source / frame-buffer side
    modport master (
        output i_vs, i_hs, i_de, i_data,
        input  o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - video geometry measurement and one-shot window capture; optional VCAP_CHECKSUM_EN adds o_checksum
module video_frame_capture #(
    parameter int IMG_W  = 225,
    parameter int IMG_H  = 225,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic               clk_i,
    input  logic               rst_n,
    video_frame_capture_if.slave vid,
    input  logic               i_capture,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [CNT_W-1:0]   o_h_active,
    output logic [CNT_W-1:0]   o_v_active,
    output logic               o_locked
`ifdef VCAP_CHECKSUM_EN
    ,
    output logic [15:0]        o_checksum
`endif
);

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  W_C     = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  H_C     = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0]  H_LAST  = CNT_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic              prev_vs;
    logic              prev_de;
    logic              frame_start;
    logic              line_end;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [CNT_W-1:0]  prev_h;
    logic [CNT_W-1:0]  prev_v;
    logic              have_prev;
    logic [ADDR_W-1:0] line_base;

    logic              wr_now;
    logic              arm;
    logic              base_clr;
    logic              base_step;
    logic              err_set;

    assign frame_start = prev_vs & ~vid.i_vs;
    assign line_end    = prev_de & ~vid.i_de;
    assign o_busy      = (state == S_ARMED) || (state == S_CAPTURE);
    assign o_done      = (state == S_DONE);

    // previous samples for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            prev_vs <= 1'b1;
            prev_de <= 1'b0;
        end else begin
            prev_vs <= vid.i_vs;
            prev_de <= vid.i_de;
        end
    end

    // saturating pixel and line counters
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else begin
            if (line_end)
                x <= '0;
            else if (vid.i_de && (x != CNT_MAX))
                x <= x + 1'b1;
            if (frame_start)
                y <= '0;
            else if (line_end && (y != CNT_MAX))
                y <= y + 1'b1;
        end
    end

    // geometry latches and frame-to-frame lock comparison
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            o_h_active <= '0;
            o_v_active <= '0;
            o_locked   <= 1'b0;
            prev_h     <= '0;
            prev_v     <= '0;
            have_prev  <= 1'b0;
        end else begin
            if (line_end)
                o_h_active <= x;
            if (frame_start) begin
                o_v_active <= y;
                o_locked   <= have_prev && (o_h_active == prev_h) && (y == prev_v) &&
                              (o_h_active != '0) && (y != '0);
                prev_h     <= o_h_active;
                prev_v     <= y;
                have_prev  <= 1'b1;
            end
        end
    end

    // capture state register
    always_ff @(posedge clk_i) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // capture sequencing: next state and datapath controls
    always_comb begin
        state_nx  = state;
        wr_now    = 1'b0;
        arm       = 1'b0;
        base_clr  = 1'b0;
        base_step = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_capture) begin
                    arm      = 1'b1;
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (frame_start) begin
                    base_clr = 1'b1;
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                wr_now = vid.i_de && (x < W_C) && (y < H_C);
                if (frame_start) begin
                    // frame ended before the window was filled
                    err_set  = 1'b1;
                    state_nx = S_DONE;
                end else if (line_end && (y < H_C)) begin
                    base_step = 1'b1;
                    if (x < W_C)
                        err_set = 1'b1;
                    if (y == H_LAST)
                        state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // row base address, registered write port and sticky error
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            line_base     <= '0;
            vid.o_wr_en   <= 1'b0;
            vid.o_wr_addr <= '0;
            vid.o_wr_data <= '0;
            o_err         <= 1'b0;
        end else begin
            if (base_clr)
                line_base <= '0;
            else if (base_step)
                line_base <= line_base + W_A;
            vid.o_wr_en <= wr_now;
            if (wr_now) begin
                vid.o_wr_addr <= line_base + ADDR_W'(x);
                vid.o_wr_data <= vid.i_data;
            end
            if (arm)
                o_err <= 1'b0;
            else if (err_set)
                o_err <= 1'b1;
        end
    end

`ifdef VCAP_CHECKSUM_EN
    // running sum of written pixels, in step with the write strobe
    always_ff @(posedge clk_i) begin
        if (!rst_n)
            o_checksum <= '0;
        else if (arm)
            o_checksum <= '0;
        else if (wr_now)
            o_checksum <= o_checksum + {8'h00, vid.i_data};
    end
`endif

endmodule

// File: tb/tb_video_frame_capture.sv
// tb/tb_video_frame_capture.sv - scoreboard bench for video_frame_capture on a reduced 8x6 window
module tb_video_frame_capture;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 5;

    logic             clk_i;
    logic             rst_n;
    logic             i_capture;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [CNT_W-1:0] o_h_active;
    logic [CNT_W-1:0] o_v_active;
    logic             o_locked;
`ifdef VCAP_CHECKSUM_EN
    logic [15:0]      o_checksum;
    logic [15:0]      last_cksum;
`endif

    video_frame_capture_if #(.ADDR_W(ADDR_W)) vif ();

    video_frame_capture #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .vid        (vif.slave),
        .i_capture  (i_capture),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_h_active (o_h_active),
        .o_v_active (o_v_active),
        .o_locked   (o_locked)
`ifdef VCAP_CHECKSUM_EN
        ,
        .o_checksum (o_checksum)
`endif
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic        exp_done[$];
    int          checks = 0;
    int          errors = 0;
    bit          const_mode = 0;
    logic [15:0] sum_model = '0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [7:0] d);
        @(negedge clk_i);
        vif.i_vs   = vs;
        vif.i_hs   = hs;
        vif.i_de   = de;
        vif.i_data = d;
    endtask

    task automatic blank_line(input logic vs, input int len);
        for (int i = 0; i < len; i++)
            drive(vs, (i == 1) ? 1'b0 : 1'b1, 1'b0, 8'h00);
    endtask

    task automatic active_line(input int width, input int row, input bit cap);
        logic [7:0] d;
        for (int px = 0; px < width; px++) begin
            d = const_mode ? 8'h01 : 8'(row * 13 + px * 7 + 5);
            if (cap && row < IMG_H && px < IMG_W) begin
                exp_wr.push_back('{addr: 8'(row * IMG_W + px), data: d});
                sum_model = sum_model + {8'h00, d};
            end
            drive(1'b1, 1'b1, 1'b1, d);
        end
        for (int i = 0; i < 4; i++)
            drive(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0, 8'h00);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"}, int'(vif.o_wr_en), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_err"}, int'(o_err), 0);
        check({tag, "_h_active"}, int'(o_h_active), 0);
        check({tag, "_v_active"}, int'(o_v_active), 0);
        check({tag, "_locked"}, int'(o_locked), 0);
    endtask

    task automatic frame(input int width, input int lines, input bit cap,
                         input int short_row, input int short_w, input int rst_row,
                         input bit geom, input int eh, input int ev, input int el);
        int w;
        blank_line(1'b0, width + 4);
        if (geom) begin
            check("h_active", int'(o_h_active), eh);
            check("v_active", int'(o_v_active), ev);
            check("locked", int'(o_locked), el);
        end
        blank_line(1'b0, width + 4);
        blank_line(1'b1, width + 4);
        for (int r = 0; r < lines; r++) begin
            if (r == rst_row) begin
                @(negedge clk_i);
                rst_n = 1'b0;
                @(negedge clk_i);
                rst_n = 1'b1;
                check_zero_outputs("mid_reset");
            end
            w = (r == short_row) ? short_w : width;
            active_line(w, r, cap && (rst_row < 0 || r < rst_row));
        end
        blank_line(1'b1, width + 4);
    endtask

    task automatic pulse_capture();
        @(negedge clk_i);
        i_capture = 1'b1;
        @(negedge clk_i);
        i_capture = 1'b0;
        sum_model = '0;
        check("err_cleared_on_arm", int'(o_err), 0);
        check("busy_when_armed", int'(o_busy), 1);
    endtask

    // monitor: pops the scoreboard on every write strobe and done pulse
    initial begin
        wr_t  e;
        logic de;
        forever begin
            @(posedge clk_i);
            #2;
            if (vif.o_wr_en) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr %0d expected no write", vif.o_wr_addr);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", int'(vif.o_wr_addr), int'(e.addr));
                    check("wr_data", int'(vif.o_wr_data), int'(e.data));
                end
            end
            if (o_done) begin
`ifdef VCAP_CHECKSUM_EN
                last_cksum = o_checksum;
`endif
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual 1 expected 0");
                end else begin
                    de = exp_done.pop_front();
                    check("done_err", int'(o_err), int'(de));
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        i_capture  = 1'b0;
        vif.i_vs   = 1'b1;
        vif.i_hs   = 1'b1;
        vif.i_de   = 1'b0;
        vif.i_data = 8'h00;
        repeat (3) @(negedge clk_i);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        frame(10, 8, 0, -1, 0, -1, 0, 0, 0, 0);
        frame(10, 8, 0, -1, 0, -1, 1, 10, 8, 0);
        pulse_capture();
        exp_done.push_back(1'b0);
        frame(10, 8, 1, -1, 0, -1, 1, 10, 8, 1);
`ifdef VCAP_CHECKSUM_EN
        check("checksum_full", int'(last_cksum), int'(sum_model));
`endif
        frame(5, 8, 0, -1, 0, -1, 1, 10, 8, 1);
        frame(10, 8, 0, -1, 0, -1, 1, 5, 8, 0);

        pulse_capture();
        exp_done.push_back(1'b1);
        frame(10, 8, 1, 2, 5, -1, 1, 10, 8, 0);

        pulse_capture();
        frame(10, 3, 1, -1, 0, -1, 1, 10, 8, 1);
        exp_done.push_back(1'b1);
        frame(10, 8, 0, -1, 0, -1, 1, 10, 3, 0);
`ifdef VCAP_CHECKSUM_EN
        check("checksum_short_frame", int'(last_cksum), int'(sum_model));
`endif

        pulse_capture();
        frame(10, 8, 1, -1, 0, 3, 1, 10, 8, 0);

        const_mode = 1;
        pulse_capture();
        exp_done.push_back(1'b0);
        frame(10, 8, 1, -1, 0, -1, 1, 10, 5, 0);
        const_mode = 0;
`ifdef VCAP_CHECKSUM_EN
        check("checksum_const", int'(last_cksum), 48);
`endif

        frame(40, 8, 0, -1, 0, -1, 1, 10, 8, 0);
        frame(10, 8, 0, -1, 0, -1, 1, 31, 8, 0);

        repeat (10) @(negedge clk_i);
        check("writes_outstanding", exp_wr.size(), 0);
        check("dones_outstanding", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_frame_capture.md
Name: video_frame_capture

Overview:
- Receive-side counterpart of the pixel-timing generator and loader path.
- Samples an 8-bit greyscale parallel video stream (vs/hs/de/data, same format as the DVI TX input) and measures its active geometry.
- On request, captures one IMG_W x IMG_H window from the top-left of the active area into a frame-buffer write port.
- Sits between a video source and a BSRAM frame buffer that the loader later reads back.

Parameters:
- IMG_W, 225, captured window width in pixels
- IMG_H, 225, captured window height in lines
- ADDR_W, 16, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- CNT_W, 12, width of the geometry counters and measurement outputs

Ports:
- clk_i  in  1  pixel-rate clock
- rst_n  in  1  synchronous active-low reset
- i_vs  in  1  vertical sync, active low
- i_hs  in  1  horizontal sync, active low; measurement only, does not affect capture
- i_de  in  1  data enable, high in active area
- i_data  in  8  pixel value
- i_capture  in  1  single-cycle arm request
- o_wr_en  out  1  frame-buffer write strobe
- o_wr_addr  out  ADDR_W  write address, row-major, y*IMG_W + x
- o_wr_data  out  8  write data
- o_busy  out  1  high in ARMED or CAPTURE
- o_done  out  1  one-cycle pulse when capture ends
- o_err  out  1  sticky capture error; cleared by the next accepted i_capture
- o_h_active  out  CNT_W  de-high cycle count of the last completed line
- o_v_active  out  CNT_W  active line count of the last completed frame
- o_locked  out  1  high while geometry is stable across frames

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0. Previous-vs register is 1; previous-de register is 0. FSM goes to IDLE.
- Reset asserted mid-capture drops any pending write the same cycle; no partial o_done is produced.
- Edge events, from registered previous samples:
  - frame_start: vs 1->0
  - line_end: de 1->0
- Pixel counter x: increments on each de-high cycle; clears on line_end.
- Line counter y: increments on line_end; clears on frame_start.
- o_h_active: loaded with the final x on line_end.
- o_v_active: loaded with y on frame_start, then y clears.
- o_locked:
  - On each frame_start, compare the new (h,v) pair with the previous frame's pair.
  - Set when equal and nonzero; clear on any mismatch.
  - The first frame after reset never sets it.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: an i_capture pulse goes to ARMED and clears o_err.
  - ARMED: frame_start goes to CAPTURE and zeroes line_base. A frame_start in the same cycle as arming is not used; the next one is.
  - CAPTURE: write when de && x<IMG_W && y<IMG_H.
    - o_wr_addr = line_base + x.
    - o_wr_en, o_wr_addr and o_wr_data are registered, giving 1-cycle latency from the input sample.
  - CAPTURE, line_end with y<IMG_H: line_base += IMG_W. If x<IMG_W at that line_end, set o_err (short line, missing pixels left unwritten).
  - CAPTURE, line_end with y==IMG_H-1: the last write has been issued; go to DONE.
  - CAPTURE, frame_start before IMG_H lines complete: set o_err, go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- i_capture is ignored in ARMED, CAPTURE and DONE.
- Address arithmetic: incremental adds only, no multiplier. The maximum address is IMG_W*IMG_H-1 and never wraps.
- Counter saturation: x and y saturate at 2^CNT_W-1; saturation does not wrap to 0.

Optional Feature:
- Macro: VCAP_CHECKSUM_EN.
- When defined:
  - Adds output o_checksum, 16 bits.
  - It holds the mod-2^16 sum of all o_wr_data values written in the current capture.
  - Clears on an accepted i_capture and updates in the same cycle as each o_wr_en.
  - Its value is final when o_done pulses.
- When undefined: port and logic are absent.

Test Plan:
- 640x480 timing (800x525 total), i_capture pulsed in the blanking interval before the next vs fall:
  - exactly 50625 writes, addresses 0..50624 ascending, no gaps
  - o_done one cycle after the 225th line's de fall; o_err=0
- Two identical 640x480 frames -> o_h_active=640, o_v_active=480, o_locked=1 after the second vs fall. Switch to 320-pixel lines -> o_locked=0 at the next vs fall, o_h_active=320.
- Source with 100 active lines -> 22500 writes, then frame_start ends the capture with o_done=1 and o_err=1. The next i_capture clears o_err.
- Line of 200 de cycles at y=5 -> writes at 1125..1324 only, o_err=1. Row 6 starts at address 1350.
- rst_n low for one cycle mid-capture at y=50 -> outputs 0 the next cycle, FSM IDLE, no o_done. The next i_capture performs a full clean capture.
- VCAP_CHECKSUM_EN defined, constant pixel 8'h01 -> o_checksum=16'hC5C1 (50625) at o_done.
